// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: COP1 issue controller. It decodes single-precision FP
// instructions, owns the 32-entry FP register file and sequences each
// instruction through IDLE -> EXEC -> WB around an external combinational FPU.
module fp_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic [31:0] gpr_in,
  output logic [31:0] gpr_out,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_en,
  input  logic [31:0] fpu_result,
  input  logic        fpu_cc,
  output logic        cc_flag
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  localparam logic [1:0] K_ILL = 2'd0;
  localparam logic [1:0] K_FPU = 2'd1;
  localparam logic [1:0] K_MTC = 2'd2;
  localparam logic [1:0] K_MFC = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b111;

  // Returns {kind, fpu_op}; anything not recognised decodes as K_ILL.
  function automatic logic [4:0] decode(input logic [31:0] w);
    logic [4:0] r;
    r = {K_ILL, 3'b000};
    if (w[31:26] == 6'b010001) begin
      if (w[25:21] == 5'b10000) begin
        case (w[5:0])
          6'h00:   r = {K_FPU, 3'b000};
          6'h01:   r = {K_FPU, 3'b001};
          6'h06:   r = {K_FPU, 3'b111};
          6'h32:   r = {K_FPU, 3'b010};
          6'h3E:   r = {K_FPU, 3'b011};
          6'h3C:   r = {K_FPU, 3'b100};
          6'h3D:   r = {K_FPU, 3'b101};
          6'h3F:   r = {K_FPU, 3'b110};
          default: r = {K_ILL, 3'b000};
        endcase
      end else if (w[25:21] == 5'b00100) begin
        r = {K_MTC, 3'b000};
      end else if (w[25:21] == 5'b00000) begin
        r = {K_MFC, 3'b000};
      end else begin
        r = {K_ILL, 3'b000};
      end
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  fs_q, fs_d;
  logic [4:0]  fd_q, fd_d;
  logic [31:0] gpr_lat_q, gpr_lat_d;
  logic [31:0] res_q, res_d;
  logic        cc_q, cc_d;
  logic        cc_flag_q, cc_flag_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic [31:0] gpr_out_q, gpr_out_d;
  logic        fpu_en_q, fpu_en_d;
  logic [2:0]  fpu_op_q, fpu_op_d;
  logic [31:0] fpu_a_q, fpu_a_d;
  logic [31:0] fpu_b_q, fpu_b_d;
  logic [31:0] fpr_q [32];
  logic [31:0] fpr_d [32];
  logic [4:0]  dec_s;

  assign dec_s = decode(instr);

  // Next-state, datapath and registered-output computation for the issue FSM.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    op_d      = op_q;
    fs_d      = fs_q;
    fd_d      = fd_q;
    gpr_lat_d = gpr_lat_q;
    res_d     = res_q;
    cc_d      = cc_q;
    cc_flag_d = cc_flag_q;
    fpr_d     = fpr_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    gpr_out_d = 32'd0;
    fpu_en_d  = 1'b0;
    fpu_op_d  = 3'b000;
    fpu_a_d   = 32'd0;
    fpu_b_d   = 32'd0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          kind_d    = dec_s[4:3];
          op_d      = dec_s[2:0];
          fs_d      = instr[15:11];
          fd_d      = instr[10:6];
          gpr_lat_d = gpr_in;
          if (dec_s[4:3] == K_ILL) begin
            // Illegal instructions skip EXEC and report in the very next cycle.
            state_d   = WB;
            done_d    = 1'b1;
            illegal_d = 1'b1;
          end else begin
            state_d = EXEC;
            if (dec_s[4:3] == K_FPU) begin
              // Operands are read from the FPR now so they are stable all of EXEC.
              fpu_en_d = 1'b1;
              fpu_op_d = dec_s[2:0];
              fpu_a_d  = fpr_q[instr[15:11]];
              fpu_b_d  = (dec_s[2:0] == OP_MOV) ? fpr_q[instr[15:11]]
                                                : fpr_q[instr[20:16]];
            end else begin
              fpu_en_d = 1'b0;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d = WB;
        done_d  = 1'b1;
        if (kind_q == K_FPU) begin
          res_d = fpu_result;
          cc_d  = fpu_cc;
        end else begin
          res_d = res_q;
        end
        if (kind_q == K_MFC) begin
          gpr_out_d = fpr_q[fs_q];
        end else begin
          gpr_out_d = 32'd0;
        end
      end
      WB: begin
        // Illegal instructions arrive here with kind K_ILL and write nothing.
        state_d = IDLE;
        if (kind_q == K_FPU) begin
          if (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_MOV) begin
            fpr_d[fd_q] = res_q;
          end else begin
            cc_flag_d = cc_q;
          end
        end else if (kind_q == K_MTC) begin
          fpr_d[fs_q] = gpr_lat_q;
        end else begin
          cc_flag_d = cc_flag_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State, register file and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      kind_q    <= K_ILL;
      op_q      <= 3'b000;
      fs_q      <= 5'd0;
      fd_q      <= 5'd0;
      gpr_lat_q <= 32'd0;
      res_q     <= 32'd0;
      cc_q      <= 1'b0;
      cc_flag_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      gpr_out_q <= 32'd0;
      fpu_en_q  <= 1'b0;
      fpu_op_q  <= 3'b000;
      fpu_a_q   <= 32'd0;
      fpu_b_q   <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        fpr_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      op_q      <= op_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      gpr_lat_q <= gpr_lat_d;
      res_q     <= res_d;
      cc_q      <= cc_d;
      cc_flag_q <= cc_flag_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      gpr_out_q <= gpr_out_d;
      fpu_en_q  <= fpu_en_d;
      fpu_op_q  <= fpu_op_d;
      fpu_a_q   <= fpu_a_d;
      fpu_b_q   <= fpu_b_d;
      fpr_q     <= fpr_d;
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign gpr_out     = gpr_out_q;
  assign fpu_en      = fpu_en_q;
  assign fpu_op      = fpu_op_q;
  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign cc_flag     = cc_flag_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl: directed-vector bench for fp_issue_ctrl with a small
// FPU stub that knows the handful of operand pairs the vectors use.
module tb_fp_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] gpr_in;
  logic [31:0] gpr_out;
  logic        done;
  logic        illegal;
  logic [2:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_en;
  logic [31:0] fpu_result;
  logic        fpu_cc;
  logic        cc_flag;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] TWO = 32'h40000000;

  fp_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .gpr_in(gpr_in), .gpr_out(gpr_out),
    .done(done), .illegal(illegal), .fpu_op(fpu_op), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_en(fpu_en), .fpu_result(fpu_result),
    .fpu_cc(fpu_cc), .cc_flag(cc_flag)
  );

  always #5 clk = ~clk;

  // FPU stub: positive operands only, so integer order equals FP order.
  always_comb begin
    fpu_result = 32'hFFFFFFFF;
    fpu_cc     = 1'b0;
    case (fpu_op)
      3'b000:  fpu_result = (fpu_a == ONE && fpu_b == TWO) ? 32'h40400000 : 32'hFFFFFFFF;
      3'b001:  fpu_result = (fpu_a == ONE && fpu_b == TWO) ? 32'hBF800000 : 32'hFFFFFFFF;
      3'b111:  fpu_result = fpu_a;
      3'b010:  fpu_cc = (fpu_a == fpu_b);
      3'b011:  fpu_cc = (fpu_a <= fpu_b);
      3'b100:  fpu_cc = (fpu_a <  fpu_b);
      3'b101:  fpu_cc = (fpu_a >= fpu_b);
      3'b110:  fpu_cc = (fpu_a >  fpu_b);
      default: fpu_cc = 1'b0;
    endcase
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_s(input logic [5:0] funct, input logic [4:0] fd,
                                        input logic [4:0] fs, input logic [4:0] ft);
    return 32'h46000000 | ({27'd0, ft} << 16) | ({27'd0, fs} << 11) | ({27'd0, fd} << 6) | {26'd0, funct};
  endfunction

  function automatic logic [31:0] enc_mtc1(input logic [4:0] fs);
    return 32'h44800000 | ({27'd0, fs} << 11);
  endfunction

  function automatic logic [31:0] enc_mfc1(input logic [4:0] fs);
    return 32'h44000000 | ({27'd0, fs} << 11);
  endfunction

  // Issue one instruction and check EXEC operands, latency and the done cycle.
  task automatic run_instr(input string tag, input logic [31:0] w, input logic [31:0] g,
                           input logic exp_ill, input logic exp_en, input logic [2:0] exp_op,
                           input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input logic [31:0] exp_gpr);
    int n;
    chk_eq({tag, " ready"}, {31'd0, instr_ready}, 32'd1);
    instr = w; gpr_in = g; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n = 1;
    while (!done && n < 6) begin
      chk_eq({tag, " fpu_en"}, {31'd0, fpu_en}, {31'd0, exp_en});
      chk_eq({tag, " fpu_op"}, {29'd0, fpu_op}, {29'd0, exp_op});
      chk_eq({tag, " fpu_a"}, fpu_a, exp_a);
      chk_eq({tag, " fpu_b"}, fpu_b, exp_b);
      chk_eq({tag, " busy"}, {31'd0, instr_ready}, 32'd0);
      tick();
      n++;
    end
    chk_eq({tag, " latency"}, n, exp_ill ? 32'd1 : 32'd2);
    chk_eq({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    chk_eq({tag, " gpr_out"}, gpr_out, exp_gpr);
    chk_eq({tag, " wb fpu_en"}, {31'd0, fpu_en}, 32'd0);
    tick();
    chk_eq({tag, " done pulse"}, {31'd0, done}, 32'd0);
    chk_eq({tag, " gpr_out idle"}, gpr_out, 32'd0);
  endtask

  logic [31:0] b2b [3];
  int          dcyc [3];

  initial begin
    int idx;
    int nd;
    logic rdy;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; gpr_in = 32'd0;
    tick(); tick();
    rst = 1'b0;
    chk_eq("rst ready", {31'd0, instr_ready}, 32'd1);
    chk_eq("rst done", {31'd0, done}, 32'd0);
    chk_eq("rst illegal", {31'd0, illegal}, 32'd0);
    chk_eq("rst fpu_en", {31'd0, fpu_en}, 32'd0);
    chk_eq("rst cc", {31'd0, cc_flag}, 32'd0);
    chk_eq("rst gpr_out", gpr_out, 32'd0);

    run_instr("mfc1 f7", enc_mfc1(5'd7), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
    run_instr("mtc1 f1", enc_mtc1(5'd1), ONE, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
    run_instr("mtc1 f2", enc_mtc1(5'd2), TWO, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
    run_instr("add f3", enc_s(6'h00, 5'd3, 5'd1, 5'd2), 32'd0, 1'b0, 1'b1, 3'b000, ONE, TWO, 32'd0);
    run_instr("mfc1 f3", enc_mfc1(5'd3), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h40400000);
    run_instr("sub f4", enc_s(6'h01, 5'd4, 5'd1, 5'd2), 32'd0, 1'b0, 1'b1, 3'b001, ONE, TWO, 32'd0);
    run_instr("mfc1 f4", enc_mfc1(5'd4), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'hBF800000);
    run_instr("mov f5", enc_s(6'h06, 5'd5, 5'd2, 5'd0), 32'd0, 1'b0, 1'b1, 3'b111, TWO, TWO, 32'd0);
    run_instr("mfc1 f5", enc_mfc1(5'd5), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, TWO);

    run_instr("c.lt", enc_s(6'h3C, 5'd0, 5'd1, 5'd2), 32'd0, 1'b0, 1'b1, 3'b100, ONE, TWO, 32'd0);
    chk_eq("c.lt cc", {31'd0, cc_flag}, 32'd1);
    run_instr("c.gt", enc_s(6'h3F, 5'd0, 5'd1, 5'd2), 32'd0, 1'b0, 1'b1, 3'b110, ONE, TWO, 32'd0);
    chk_eq("c.gt cc", {31'd0, cc_flag}, 32'd0);
    run_instr("c.eq", enc_s(6'h32, 5'd0, 5'd2, 5'd5), 32'd0, 1'b0, 1'b1, 3'b010, TWO, TWO, 32'd0);
    chk_eq("c.eq cc", {31'd0, cc_flag}, 32'd1);
    run_instr("cmp f0", enc_mfc1(5'd0), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
    run_instr("cmp f3", enc_mfc1(5'd3), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h40400000);

    run_instr("illegal", 32'h46000007, 32'd0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
    chk_eq("illegal cc", {31'd0, cc_flag}, 32'd1);
    run_instr("ill f0", enc_mfc1(5'd0), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
    run_instr("ill f2", enc_mfc1(5'd2), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, TWO);

    // Reset while add.s f6,f1,f2 is in EXEC.
    instr = enc_s(6'h00, 5'd6, 5'd1, 5'd2); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk_eq("abort in exec", {31'd0, fpu_en}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("abort done", {31'd0, done}, 32'd0);
    chk_eq("abort ready", {31'd0, instr_ready}, 32'd1);
    chk_eq("abort cc", {31'd0, cc_flag}, 32'd0);
    tick();
    chk_eq("abort no late done", {31'd0, done}, 32'd0);
    run_instr("abort f6", enc_mfc1(5'd6), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
    run_instr("abort f1", enc_mfc1(5'd1), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);

    // Back-to-back: instr_valid stays high, next instruction presented after each acceptance.
    b2b[0] = enc_mtc1(5'd8);
    b2b[1] = enc_mtc1(5'd9);
    b2b[2] = enc_mfc1(5'd8);
    idx = 0; nd = 0;
    instr = b2b[0]; gpr_in = 32'h11111111; instr_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      rdy = instr_ready;
      tick();
      if (rdy && idx < 3) begin
        idx++;
        if (idx < 3) begin
          instr  = b2b[idx];
          gpr_in = 32'h22222222;
        end else begin
          instr_valid = 1'b0;
        end
      end
      if (done) begin
        if (nd < 3) dcyc[nd] = c;
        if (nd == 2) chk_eq("b2b mfc1 f8", gpr_out, 32'h11111111);
        nd++;
      end
    end
    instr_valid = 1'b0;
    chk_eq("b2b done count", nd, 32'd3);
    chk_eq("b2b gap 1", dcyc[1] - dcyc[0], 32'd3);
    chk_eq("b2b gap 2", dcyc[2] - dcyc[1], 32'd3);
    run_instr("b2b f9", enc_mfc1(5'd9), 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h22222222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
